// File: rtl/dma_pkg.sv
// Shared types for the DMA read-path frame scheduler: FSM state encoding and
// the read command as it leaves the scheduler.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    WAIT_PAIR  = 3'd2,
    CALC_EVEN  = 3'd3,
    ISSUE_EVEN = 3'd4,
    CALC_ODD   = 3'd5,
    ISSUE_ODD  = 3'd6
  } sched_state_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
    logic                  odd;
    logic                  last;
  } read_cmd_t;

endpackage

// File: rtl/dma_line_scheduler_if.sv
// Descriptor, line-pair and read-command channels of the line scheduler.
// Every *_valid/*_ready pair transfers on a clock edge where both are high; a
// source holds valid and its payload unchanged until that edge, and ready
// never depends combinationally on valid.
interface dma_line_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);

  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [ADDR_W-1:0] cfg_base_i;
  logic [ADDR_W-1:0] cfg_stride_i;
  logic [LEN_W-1:0]  cfg_hsize_i;
  logic [ADDR_W-1:0] cfg_vsize_i;

  logic              lnf_new_frame_o;
  logic [ADDR_W-1:0] lnf_vsize_o;
  logic              lnf_valid_i;
  logic              lnf_ready_o;
  logic [ADDR_W-1:0] lnf_even_i;
  logic [ADDR_W-1:0] lnf_odd_i;
  logic              lnf_last_i;

  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [LEN_W-1:0]  cmd_len_o;
  logic              cmd_odd_o;
  logic              cmd_last_o;

  modport slave (
    input  cfg_valid_i, cfg_base_i, cfg_stride_i, cfg_hsize_i, cfg_vsize_i,
    output cfg_ready_o,
    output lnf_new_frame_o, lnf_vsize_o, lnf_ready_o,
    input  lnf_valid_i, lnf_even_i, lnf_odd_i, lnf_last_i,
    output cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o,
    input  cmd_ready_i
  );

  modport master (
    output cfg_valid_i, cfg_base_i, cfg_stride_i, cfg_hsize_i, cfg_vsize_i,
    input  cfg_ready_o,
    input  lnf_new_frame_o, lnf_vsize_o, lnf_ready_o,
    output lnf_valid_i, lnf_even_i, lnf_odd_i, lnf_last_i,
    input  cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o,
    output cmd_ready_i
  );

endinterface

// File: rtl/dma_line_addr_calc.sv
// Registered line start address: base + line * stride, one cycle latency.
// Product and sum both wrap to ADDR_W bits.
module dma_line_addr_calc #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [ADDR_W-1:0] line_i,
  output logic [ADDR_W-1:0] addr_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_o <= '0;
    end else if (en_i) begin
      addr_o <= base_i + line_i * stride_i;
    end
  end

endmodule

// File: rtl/dma_line_scheduler.sv
// Frame scheduler: takes one descriptor, kicks the line former, and turns
// each even/odd line pair into two read commands (even first).
module dma_line_scheduler
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dma_line_scheduler_if.slave  bus,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output sched_state_t         dbg_state_o
);

  sched_state_t      state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  hsize_q;
  logic [ADDR_W-1:0] vsize_q;
  logic [ADDR_W-1:0] even_q;
  logic [ADDR_W-1:0] odd_q;
  logic              last_q;
  logic              new_frame_q;
  logic              done_q;

  logic              calc_en;
  logic [ADDR_W-1:0] calc_line;
  logic [ADDR_W-1:0] addr_w;
  read_cmd_t         cmd_c;

  // One calculator serves both phases; its output holds through ISSUE_*.
  assign calc_en   = (state_q == CALC_EVEN) || (state_q == CALC_ODD);
  assign calc_line = (state_q == CALC_ODD) ? odd_q : even_q;

  dma_line_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (calc_en),
    .base_i   (base_q),
    .stride_i (stride_q),
    .line_i   (calc_line),
    .addr_o   (addr_w)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      hsize_q     <= '0;
      vsize_q     <= '0;
      even_q      <= '0;
      odd_q       <= '0;
      last_q      <= 1'b0;
      new_frame_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      new_frame_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid_i) begin
            base_q      <= bus.cfg_base_i;
            stride_q    <= bus.cfg_stride_i;
            hsize_q     <= bus.cfg_hsize_i;
            vsize_q     <= bus.cfg_vsize_i;
            new_frame_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: state_q <= WAIT_PAIR;
        WAIT_PAIR: begin
          if (bus.lnf_valid_i) begin
            even_q  <= bus.lnf_even_i;
            odd_q   <= bus.lnf_odd_i;
            last_q  <= bus.lnf_last_i;
            state_q <= CALC_EVEN;
          end
        end
        CALC_EVEN: state_q <= ISSUE_EVEN;
        ISSUE_EVEN: begin
          if (bus.cmd_ready_i) state_q <= CALC_ODD;
        end
        CALC_ODD: state_q <= ISSUE_ODD;
        ISSUE_ODD: begin
          if (bus.cmd_ready_i) begin
            if (last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_PAIR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_c      = '0;
    cmd_c.addr = DMA_ADDR_W'(addr_w);
    cmd_c.len  = DMA_LEN_W'(hsize_q);
    cmd_c.odd  = (state_q == ISSUE_ODD);
    cmd_c.last = (state_q == ISSUE_ODD) && last_q;
  end

  // Handshake strobes decode from state only, never from inputs.
  assign bus.cfg_ready_o     = (state_q == IDLE);
  assign bus.lnf_ready_o     = (state_q == WAIT_PAIR);
  assign bus.cmd_valid_o     = (state_q == ISSUE_EVEN) || (state_q == ISSUE_ODD);
  assign bus.lnf_new_frame_o = new_frame_q;
  assign bus.lnf_vsize_o     = vsize_q;
  assign bus.cmd_addr_o      = ADDR_W'(cmd_c.addr);
  assign bus.cmd_len_o       = LEN_W'(cmd_c.len);
  assign bus.cmd_odd_o       = cmd_c.odd;
  assign bus.cmd_last_o      = cmd_c.last;

  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dma_line_scheduler.sv
// Directed bench for dma_line_scheduler: the bench plays both the line former
// and the read engine, with hand-computed command addresses queued per frame.
module tb_dma_line_scheduler;
  import dma_pkg::*;

  localparam int AW = 32;
  localparam int LW = 16;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy;
  logic         frame_done;
  sched_state_t dbg_state;

  dma_line_scheduler_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  dma_line_scheduler #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] pair_e[$];
  logic [AW-1:0] pair_o[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [LW-1:0] hsize, input logic [AW-1:0] vsize);
    int waited;
    bus.cfg_valid_i  = 1'b1;
    bus.cfg_base_i   = base;
    bus.cfg_stride_i = stride;
    bus.cfg_hsize_i  = hsize;
    bus.cfg_vsize_i  = vsize;
    waited = 0;
    while (!bus.cfg_ready_o && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    if (waited >= TIMEOUT) check("cfg_ready_timeout", 64'(waited), 64'(0));
    tick();
    bus.cfg_valid_i = 1'b0;
  endtask

  task automatic send_pair(input logic [AW-1:0] e, input logic [AW-1:0] o, input logic last);
    int waited;
    bus.lnf_valid_i = 1'b1;
    bus.lnf_even_i  = e;
    bus.lnf_odd_i   = o;
    bus.lnf_last_i  = last;
    waited = 0;
    while (!bus.lnf_ready_o && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    if (waited >= TIMEOUT) check("lnf_ready_timeout", 64'(waited), 64'(0));
    tick();
    bus.lnf_valid_i = 1'b0;
  endtask

  // Consumes one command; cmd_ready is low until valid is seen, then optionally
  // stalled for a random number of cycles.
  task automatic expect_cmd(input logic odd, input logic last, input logic [LW-1:0] len,
                            input logic stall);
    int waited;
    int n;
    logic [AW-1:0] exp_addr;
    waited = 0;
    while (!bus.cmd_valid_o && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    check("cmd_latency", 64'(waited), 64'(1));
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("cmd_addr", 64'(bus.cmd_addr_o), 64'(exp_addr));
    check("cmd_odd", 64'(bus.cmd_odd_o), 64'(odd));
    check("cmd_last", 64'(bus.cmd_last_o), 64'(last));
    check("cmd_len", 64'(bus.cmd_len_o), 64'(len));
    if (stall) begin
      n = 0;
      while ($urandom_range(0, 99) < 30 && n < 20) begin
        bus.cmd_ready_i = 1'b0;
        tick();
        n++;
        check("stall_valid", 64'(bus.cmd_valid_o), 64'(1));
        check("stall_addr", 64'(bus.cmd_addr_o), 64'(exp_addr));
        check("stall_odd", 64'(bus.cmd_odd_o), 64'(odd));
        check("stall_last", 64'(bus.cmd_last_o), 64'(last));
      end
    end
    bus.cmd_ready_i = 1'b1;
    tick();
    bus.cmd_ready_i = 1'b0;
  endtask

  task automatic run_frame(input logic [LW-1:0] hsize, input logic stall);
    logic last;
    for (int i = 0; i < pair_e.size(); i++) begin
      last = (i == pair_e.size() - 1);
      send_pair(pair_e[i], pair_o[i], last);
      expect_cmd(1'b0, 1'b0, hsize, stall);
      expect_cmd(1'b1, last, hsize, stall);
      if (!last) begin
        check("no_early_done", 64'(frame_done), 64'(0));
        check("busy_mid_frame", 64'(busy), 64'(1));
      end
    end
    check("frame_done_pulse", 64'(frame_done), 64'(1));
    check("busy_drops_with_done", 64'(busy), 64'(0));
    check("cfg_ready_after_frame", 64'(bus.cfg_ready_o), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic load_main_frame();
    pair_e = '{32'd4, 32'd5, 32'd6, 32'd7};
    pair_o = '{32'd3, 32'd2, 32'd1, 32'd0};
    exp_q  = '{32'h1400, 32'h1300, 32'h1500, 32'h1200,
               32'h1600, 32'h1100, 32'h1700, 32'h1000};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.cfg_valid_i  = 1'b0;
    bus.cfg_base_i   = '0;
    bus.cfg_stride_i = '0;
    bus.cfg_hsize_i  = '0;
    bus.cfg_vsize_i  = '0;
    bus.lnf_valid_i  = 1'b0;
    bus.lnf_even_i   = '0;
    bus.lnf_odd_i    = '0;
    bus.lnf_last_i   = 1'b0;
    bus.cmd_ready_i  = 1'b0;

    // Reset values
    #12;
    check("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_new_frame", 64'(bus.lnf_new_frame_o), 64'(0));
    check("rst_lnf_ready", 64'(bus.lnf_ready_o), 64'(0));
    check("rst_cmd_valid", 64'(bus.cmd_valid_o), 64'(0));
    check("rst_cmd_addr", 64'(bus.cmd_addr_o), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    tick();

    // Stale pair offered in IDLE is not consumed
    bus.lnf_valid_i = 1'b1;
    bus.lnf_even_i  = 32'd9;
    bus.lnf_odd_i   = 32'd9;
    bus.lnf_last_i  = 1'b1;
    tick();
    tick();
    check("idle_lnf_ready", 64'(bus.lnf_ready_o), 64'(0));
    check("idle_state_kept", 64'(dbg_state), 64'(IDLE));

    // Main frame, command side always ready
    load_main_frame();
    send_cfg(32'h1000, 32'h100, 16'd63, 32'd7);
    check("start_new_frame", 64'(bus.lnf_new_frame_o), 64'(1));
    check("start_busy", 64'(busy), 64'(1));
    check("start_cfg_ready", 64'(bus.cfg_ready_o), 64'(0));
    check("start_lnf_ready", 64'(bus.lnf_ready_o), 64'(0));
    check("start_vsize", 64'(bus.lnf_vsize_o), 64'(7));
    bus.lnf_valid_i = 1'b0;
    tick();
    check("wait_new_frame_low", 64'(bus.lnf_new_frame_o), 64'(0));
    check("wait_lnf_ready", 64'(bus.lnf_ready_o), 64'(1));
    check("wait_state", 64'(dbg_state), 64'(WAIT_PAIR));
    run_frame(16'd63, 1'b0);
    tick();
    check("done_single_pulse", 64'(frame_done), 64'(0));

    // Same frame under random back-pressure
    load_main_frame();
    send_cfg(32'h1000, 32'h100, 16'd63, 32'd7);
    run_frame(16'd63, 1'b1);
    tick();

    // Back-to-back: second descriptor held while the first frame runs
    pair_e = '{32'd2, 32'd3};
    pair_o = '{32'd1, 32'd0};
    exp_q  = '{32'h2080, 32'h2040, 32'h20C0, 32'h2000};
    send_cfg(32'h2000, 32'h40, 16'd31, 32'd3);
    bus.cfg_valid_i  = 1'b1;
    bus.cfg_base_i   = 32'h8000;
    bus.cfg_stride_i = 32'h10;
    bus.cfg_hsize_i  = 16'd15;
    bus.cfg_vsize_i  = 32'd1;
    check("b2b_cfg_blocked", 64'(bus.cfg_ready_o), 64'(0));
    run_frame(16'd31, 1'b0);
    tick();
    bus.cfg_valid_i = 1'b0;
    check("b2b_new_frame", 64'(bus.lnf_new_frame_o), 64'(1));
    check("b2b_vsize", 64'(bus.lnf_vsize_o), 64'(1));
    check("b2b_busy", 64'(busy), 64'(1));
    pair_e = '{32'd1};
    pair_o = '{32'd1};
    exp_q  = '{32'h8010, 32'h8010};
    run_frame(16'd15, 1'b0);
    tick();

    // Address wrap
    pair_e = '{32'd2, 32'd3};
    pair_o = '{32'd1, 32'd0};
    exp_q  = '{32'h0000_0100, 32'h0000_0000, 32'h0000_0200, 32'hFFFF_FF00};
    send_cfg(32'hFFFF_FF00, 32'h100, 16'd7, 32'd3);
    run_frame(16'd7, 1'b0);
    tick();

    // Zero stride
    exp_q = '{32'hABCD_0000, 32'hABCD_0000, 32'hABCD_0000, 32'hABCD_0000};
    send_cfg(32'hABCD_0000, 32'h0, 16'd100, 32'd3);
    run_frame(16'd100, 1'b0);
    tick();

    // Reset while in ISSUE_EVEN
    send_cfg(32'h1000, 32'h100, 16'd63, 32'd7);
    send_pair(32'd4, 32'd3, 1'b0);
    tick();
    check("pre_rst_state", 64'(dbg_state), 64'(ISSUE_EVEN));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cmd_valid", 64'(bus.cmd_valid_o), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_cfg_ready", 64'(bus.cfg_ready_o), 64'(1));
    check("arst_cmd_addr", 64'(bus.cmd_addr_o), 64'(0));
    check("arst_cmd_len", 64'(bus.cmd_len_o), 64'(0));
    check("arst_vsize", 64'(bus.lnf_vsize_o), 64'(0));
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    load_main_frame();
    send_cfg(32'h1000, 32'h100, 16'd63, 32'd7);
    check("post_rst_new_frame", 64'(bus.lnf_new_frame_o), 64'(1));
    run_frame(16'd63, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_line_scheduler.md
# dma_line_scheduler

Frame-level controller for the DMA read path. Accepts one frame descriptor (base, stride, line size, line count), starts the line-number former, and consumes its even/odd line-number pairs. Each pair becomes two memory read commands (even line, then odd line) for the DMA read engine, with the address computed as base + line × stride. It sits between the DMA register/config block and the read-command channel, with the line-number former as its direct peer.

## Interface
Parameters:
- ADDR_W, 32, address and line-number width
- LEN_W, 16, line length field width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_valid_i  in  1  descriptor valid
- cfg_ready_o  out  1  descriptor accepted when high with cfg_valid_i
- cfg_base_i  in  ADDR_W  frame base byte address
- cfg_stride_i  in  ADDR_W  byte distance between consecutive lines
- cfg_hsize_i  in  LEN_W  bytes per line minus 1
- cfg_vsize_i  in  ADDR_W  lines minus 1
- lnf_new_frame_o  out  1  one-cycle start pulse to line former
- lnf_vsize_o  out  ADDR_W  latched vsize, stable while busy
- lnf_valid_i  in  1  line pair valid
- lnf_ready_o  out  1  line pair accepted
- lnf_even_i, lnf_odd_i  in  ADDR_W  line numbers
- lnf_last_i  in  1  final pair of frame
- cmd_valid_o  out  1  read command valid
- cmd_ready_i  in  1  read command accepted
- cmd_addr_o  out  ADDR_W  line start address
- cmd_len_o  out  LEN_W  latched hsize
- cmd_odd_o  out  1  0 = even line, 1 = odd line
- cmd_last_o  out  1  final command of frame
- busy_o  out  1  high in every state except IDLE
- frame_done_o  out  1  one-cycle pulse after the final command handshake

## Operation
- FSM states: IDLE, START, WAIT_PAIR, CALC_EVEN, ISSUE_EVEN, CALC_ODD, ISSUE_ODD.
- IDLE:
  - cfg_ready_o=1.
  - On a cfg handshake: latch base, stride, hsize and vsize, then go to START.
- START: lnf_new_frame_o=1 for exactly one cycle, then go to WAIT_PAIR.
- WAIT_PAIR:
  - lnf_ready_o=1.
  - On a handshake: capture even, odd and last, then go to CALC_EVEN.
- CALC_EVEN: addr_q <= base + even × stride, then go to ISSUE_EVEN.
- ISSUE_EVEN:
  - cmd_valid_o=1, cmd_odd_o=0.
  - On cmd_ready_i: go to CALC_ODD.
- CALC_ODD: addr_q <= base + odd × stride, then go to ISSUE_ODD.
- ISSUE_ODD:
  - cmd_valid_o=1, cmd_odd_o=1, cmd_last_o=captured last.
  - On handshake with last=1: go to IDLE and pulse frame_done_o on the next cycle.
  - On handshake with last=0: go to WAIT_PAIR.
- Arithmetic:
  - Product is truncated to the low ADDR_W bits; the sum wraps modulo 2^ADDR_W.
  - stride=0 is legal: every address equals base.
- Repeated line numbers from the former's mirror expansion are issued as-is; no deduplication.
- cmd_len_o = latched hsize for every command of the frame.

## Timing
- Reset values:
  - Zero: all outputs except cfg_ready_o and all internal registers; state=IDLE.
  - cfg_ready_o=1.
- Registered outputs: lnf_new_frame_o and frame_done_o.
- Decoded from state (no combinational path from inputs): cfg_ready_o, lnf_ready_o, cmd_valid_o and busy_o.
- Latency:
  - Descriptor handshake at cycle N gives lnf_new_frame_o at N+1.
  - Earliest pair handshake is N+2.
  - Pair handshake at M gives even cmd_valid_o at M+2.
  - Even handshake at K gives odd cmd_valid_o at K+2.
- Handshake rules:
  - cmd_valid_o, cmd_addr_o, cmd_odd_o and cmd_last_o are held stable until cmd_ready_i.
  - Back-pressure of any length is tolerated.
- cfg_valid_i while busy: cfg_ready_o=0; the descriptor waits and is accepted in the first IDLE cycle.
- A descriptor arriving in the same cycle as frame_done_o is accepted; the IDLE→START turnaround costs no extra cycle.
- lnf_valid_i outside WAIT_PAIR is ignored (not consumed).
- Reset asserted mid-frame: the block returns immediately to reset values.
  - The line former is not reset by this block.
  - The next lnf_new_frame_o re-initialises the former.
  - A stale pair offered before that pulse is never accepted, because the block only enters WAIT_PAIR after START.

## Structure
- dma_pkg holds the sched_state_t enum and the read_cmd_t struct (addr, len, odd, last).
- Natural sub-module: dma_line_addr_calc, a registered base + line × stride unit with 1-cycle latency, instantiated once and shared by the even and odd phases.
- The line former is instantiated alongside this block by the parent, not inside it.

## Test plan
- Descriptor base=0x1000, stride=0x100, hsize=63, vsize=7; former in forward mode; cmd_ready_i=1.
  - Commands follow the former's even/odd sequence, e.g. the first pair (4,3) gives 0x1400 then 0x1300.
  - cmd_len_o=63 throughout; cmd_last_o only on the final odd command.
  - frame_done_o pulses once; busy_o drops the same cycle.
- Same frame with cmd_ready_i toggling randomly 30%:
  - Address, odd and last are stable while stalled.
  - The sequence is identical to the first case.
- Back-to-back descriptors, the second held asserted during the first frame:
  - Accepted in the cycle frame_done_o pulses.
  - lnf_new_frame_o follows on the next cycle.
- base=0xFFFF_FF00, stride=0x100, line 2 gives cmd_addr_o=0x0000_0100 (wrap); stride=0 gives every address = base.
- rst_ni asserted while in ISSUE_EVEN:
  - Outputs go to reset values asynchronously.
  - The following descriptor runs a complete, correct frame from the first pair.
- lnf_valid_i forced high during IDLE and START: no pair consumed (lnf_ready_o=0) until WAIT_PAIR.
